// File: rtl/mem_port_requester_if.sv
// rtl/mem_port_requester_if.sv - client and cluster-port signal bundle for mem_port_requester
interface mem_port_requester_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 2
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [DATA_W-1:0] req_data;

    logic [TAG_W-1:0]  port_req_tag_out;
    logic [ADDR_W-1:0] port_addr;
    logic [DATA_W-1:0] port_data_in;
    logic              port_wen;
    logic              port_valid;
    logic              freeze_inputs;
    logic [TAG_W-1:0]  port_req_tag_in;
    logic [DATA_W-1:0] port_data_out;
    logic              port_valid_out;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_wen;
    logic              err_unexpected_rsp;

    modport master (
        input  req_valid, req_addr, req_wen, req_data,
        output req_ready,
        output port_req_tag_out, port_addr, port_data_in, port_wen, port_valid,
        input  freeze_inputs, port_req_tag_in, port_data_out, port_valid_out,
        output rsp_valid, rsp_data, rsp_wen,
        input  rsp_ready,
        output err_unexpected_rsp
    );

    modport slave (
        output req_valid, req_addr, req_wen, req_data,
        input  req_ready,
        input  port_req_tag_out, port_addr, port_data_in, port_wen, port_valid,
        output freeze_inputs, port_req_tag_in, port_data_out, port_valid_out,
        input  rsp_valid, rsp_data, rsp_wen,
        output rsp_ready,
        input  err_unexpected_rsp
    );
endinterface

// File: rtl/mem_port_requester.sv
// rtl/mem_port_requester.sv - tagged request issue with in-order response reorder buffer
module mem_port_requester #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_requester_if.master bus
);
    localparam int DEPTH = 2 ** TAG_W;
    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W + 1)'(DEPTH);

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count;
    logic [DEPTH-1:0]  rob_alloc;
    logic [DEPTH-1:0]  rob_done;
    logic [DEPTH-1:0]  rob_wen;
    logic [DATA_W-1:0] rob_data [DEPTH];

    logic              pv_q;
    logic [TAG_W-1:0]  tag_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wen_q;
    logic              err_q;

    logic req_ready_c;
    logic accept;
    logic take;
    logic retire;
    logic rsp_hit;

    // The output register may reload in the same cycle the cluster takes it.
    assign req_ready_c = (count < FULL_COUNT) & (~pv_q | ~bus.freeze_inputs);
    assign accept      = bus.req_valid & req_ready_c;
    assign take        = pv_q & ~bus.freeze_inputs;
    assign retire      = rob_done[head] & bus.rsp_ready;
    assign rsp_hit     = rob_alloc[bus.port_req_tag_in] & ~rob_done[bus.port_req_tag_in];

    assign bus.req_ready          = req_ready_c;
    assign bus.port_valid         = pv_q;
    assign bus.port_req_tag_out   = tag_q;
    assign bus.port_addr          = addr_q;
    assign bus.port_data_in       = wdata_q;
    assign bus.port_wen           = wen_q;
    assign bus.rsp_valid          = rob_done[head];
    assign bus.rsp_data           = rob_data[head];
    assign bus.rsp_wen            = rob_wen[head];
    assign bus.err_unexpected_rsp = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            rob_alloc <= '0;
            rob_done  <= '0;
            rob_wen   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob_data[i] <= '0;
            end
            pv_q    <= 1'b0;
            tag_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                pv_q    <= 1'b1;
                tag_q   <= tail;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_data;
                wen_q   <= bus.req_wen;
            end else if (take) begin
                pv_q <= 1'b0;
            end

            // A response to a free or already-completed slot is dropped, never stored.
            if (bus.port_valid_out) begin
                if (rsp_hit) begin
                    rob_done[bus.port_req_tag_in] <= 1'b1;
                    rob_data[bus.port_req_tag_in] <= bus.port_data_out;
                end else begin
                    err_q <= 1'b1;
                end
            end

            if (retire) begin
                rob_alloc[head] <= 1'b0;
                rob_done[head]  <= 1'b0;
                head            <= head + 1'b1;
            end

            if (accept) begin
                rob_alloc[tail] <= 1'b1;
                rob_done[tail]  <= 1'b0;
                rob_wen[tail]   <= bus.req_wen;
                tail            <= tail + 1'b1;
            end

            case ({accept, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_requester.sv
// tb/tb_mem_port_requester.sv - directed self-checking bench for mem_port_requester
module tb_mem_port_requester;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    mem_port_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic issue_n(input int n, input logic [11:0] base, input logic [11:0] stride,
                           input logic wen, input logic [15:0] dbase, input logic [1:0] tag0);
        logic [1:0] t;
        for (int i = 0; i < n; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = base + stride * 12'(i);
            bus.req_wen   = wen;
            bus.req_data  = dbase + 16'(i);
            sample;
            expect_eq("issue_req_ready", 32'(bus.req_ready), 32'd1);
            if (i > 0) begin
                t = tag0 + 2'(i - 1);
                expect_eq("issue_port_valid", 32'(bus.port_valid), 32'd1);
                expect_eq("issue_tag", 32'(bus.port_req_tag_out), 32'(t));
                expect_eq("issue_addr", 32'(bus.port_addr), 32'(base + stride * 12'(i - 1)));
            end
            next_cycle;
        end
        bus.req_valid = 1'b0;
        t = tag0 + 2'(n - 1);
        sample;
        expect_eq("issue_last_valid", 32'(bus.port_valid), 32'd1);
        expect_eq("issue_last_tag", 32'(bus.port_req_tag_out), 32'(t));
        expect_eq("issue_last_addr", 32'(bus.port_addr), 32'(base + stride * 12'(n - 1)));
        next_cycle;
        sample;
        expect_eq("issue_drained", 32'(bus.port_valid), 32'd0);
        next_cycle;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  ooo_tag  [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
        logic        ooo_vld  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] ooo_data [8] = '{16'h0, 16'h0, 16'hB000, 16'h0, 16'hB001, 16'hB002, 16'hB003, 16'h0};

        reset              = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_addr       = '0;
        bus.req_wen        = 1'b0;
        bus.req_data       = '0;
        bus.freeze_inputs  = 1'b0;
        bus.port_req_tag_in = '0;
        bus.port_data_out  = '0;
        bus.port_valid_out = 1'b0;
        bus.rsp_ready      = 1'b0;
        next_cycle;
        next_cycle;
        reset = 1'b0;

        // reset state
        sample;
        expect_eq("rst_port_valid", 32'(bus.port_valid), 32'd0);
        expect_eq("rst_port_tag", 32'(bus.port_req_tag_out), 32'd0);
        expect_eq("rst_port_addr", 32'(bus.port_addr), 32'd0);
        expect_eq("rst_port_data", 32'(bus.port_data_in), 32'd0);
        expect_eq("rst_port_wen", 32'(bus.port_wen), 32'd0);
        expect_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        expect_eq("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        expect_eq("rst_rsp_wen", 32'(bus.rsp_wen), 32'd0);
        expect_eq("rst_err", 32'(bus.err_unexpected_rsp), 32'd0);
        expect_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        expect_eq("rst_count", 32'(dut.count), 32'd0);
        next_cycle;

        // back-to-back reads, in-order return
        issue_n(4, 12'h001, 12'h400, 1'b0, 16'h0, 2'd0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 12'hFFF;
        sample;
        expect_eq("full_req_ready", 32'(bus.req_ready), 32'd0);
        next_cycle;
        bus.req_valid = 1'b0;
        sample;
        expect_eq("full_no_accept", 32'(bus.port_valid), 32'd0);
        next_cycle;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.port_valid_out  = 1'b1;
            bus.port_req_tag_in = 2'(i);
            bus.port_data_out   = 16'hA000 + 16'(i);
            sample;
            expect_eq("inord_rsp_valid", 32'(bus.rsp_valid), (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) expect_eq("inord_rsp_data", 32'(bus.rsp_data), 32'(16'hA000 + 16'(i - 1)));
            if (i == 0) expect_eq("inord_full_ready", 32'(bus.req_ready), 32'd0);
            next_cycle;
        end
        bus.port_valid_out = 1'b0;
        sample;
        expect_eq("inord_last_valid", 32'(bus.rsp_valid), 32'd1);
        expect_eq("inord_last_data", 32'(bus.rsp_data), 32'hA003);
        next_cycle;
        sample;
        expect_eq("inord_empty", 32'(bus.rsp_valid), 32'd0);
        expect_eq("inord_ready_back", 32'(bus.req_ready), 32'd1);
        next_cycle;

        // freeze hold on a pending write
        bus.req_valid = 1'b1;
        bus.req_addr  = 12'h123;
        bus.req_data  = 16'hBEEF;
        bus.req_wen   = 1'b1;
        sample;
        expect_eq("frz_accept_ready", 32'(bus.req_ready), 32'd1);
        next_cycle;
        bus.req_addr      = 12'h777;
        bus.req_data      = 16'h0;
        bus.req_wen       = 1'b0;
        bus.freeze_inputs = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample;
            expect_eq("frz_valid", 32'(bus.port_valid), 32'd1);
            expect_eq("frz_tag", 32'(bus.port_req_tag_out), 32'd0);
            expect_eq("frz_addr", 32'(bus.port_addr), 32'h123);
            expect_eq("frz_data", 32'(bus.port_data_in), 32'hBEEF);
            expect_eq("frz_wen", 32'(bus.port_wen), 32'd1);
            expect_eq("frz_req_ready", 32'(bus.req_ready), 32'd0);
            next_cycle;
        end
        bus.req_valid     = 1'b0;
        bus.freeze_inputs = 1'b0;
        sample;
        expect_eq("frz_take_valid", 32'(bus.port_valid), 32'd1);
        expect_eq("frz_take_addr", 32'(bus.port_addr), 32'h123);
        expect_eq("frz_unfrozen_ready", 32'(bus.req_ready), 32'd1);
        next_cycle;
        sample;
        expect_eq("frz_taken", 32'(bus.port_valid), 32'd0);
        next_cycle;
        bus.port_valid_out  = 1'b1;
        bus.port_req_tag_in = 2'd0;
        bus.port_data_out   = 16'h5555;
        sample;
        expect_eq("wack_no_bypass", 32'(bus.rsp_valid), 32'd0);
        next_cycle;
        bus.port_valid_out = 1'b0;
        sample;
        expect_eq("wack_valid", 32'(bus.rsp_valid), 32'd1);
        expect_eq("wack_wen", 32'(bus.rsp_wen), 32'd1);
        next_cycle;
        sample;
        expect_eq("wack_retired", 32'(bus.rsp_valid), 32'd0);
        next_cycle;

        // unexpected response on an empty buffer
        bus.port_valid_out  = 1'b1;
        bus.port_req_tag_in = 2'd3;
        bus.port_data_out   = 16'h1234;
        sample;
        expect_eq("unexp_err_before", 32'(bus.err_unexpected_rsp), 32'd0);
        next_cycle;
        bus.port_valid_out = 1'b0;
        sample;
        expect_eq("unexp_err_set", 32'(bus.err_unexpected_rsp), 32'd1);
        expect_eq("unexp_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        expect_eq("unexp_count", 32'(dut.count), 32'd0);
        expect_eq("unexp_alloc", 32'(dut.rob_alloc), 32'd0);
        expect_eq("unexp_done", 32'(dut.rob_done), 32'd0);
        next_cycle;
        next_cycle;
        sample;
        expect_eq("unexp_err_sticky", 32'(bus.err_unexpected_rsp), 32'd1);
        next_cycle;

        // reset with three requests outstanding and a fourth presented
        issue_n(3, 12'h200, 12'h001, 1'b0, 16'h0, 2'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 12'h2FF;
        reset         = 1'b1;
        next_cycle;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        sample;
        expect_eq("mrst_port_valid", 32'(bus.port_valid), 32'd0);
        expect_eq("mrst_port_addr", 32'(bus.port_addr), 32'd0);
        expect_eq("mrst_port_tag", 32'(bus.port_req_tag_out), 32'd0);
        expect_eq("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        expect_eq("mrst_err", 32'(bus.err_unexpected_rsp), 32'd0);
        expect_eq("mrst_count", 32'(dut.count), 32'd0);
        expect_eq("mrst_req_ready", 32'(bus.req_ready), 32'd1);
        next_cycle;

        // out-of-order return 2,0,3,1; first request after reset must carry tag 0
        issue_n(4, 12'h010, 12'h001, 1'b0, 16'h0, 2'd0);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.port_valid_out = (c < 4);
            if (c < 4) begin
                bus.port_req_tag_in = ooo_tag[c];
                bus.port_data_out   = 16'hB000 + 16'(ooo_tag[c]);
            end
            sample;
            expect_eq("ooo_rsp_valid", 32'(bus.rsp_valid), 32'(ooo_vld[c]));
            if (ooo_vld[c]) expect_eq("ooo_rsp_data", 32'(bus.rsp_data), 32'(ooo_data[c]));
            next_cycle;
        end
        bus.port_valid_out = 1'b0;

        // client backpressure while all four complete
        issue_n(4, 12'h020, 12'h001, 1'b0, 16'h0, 2'd0);
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.port_valid_out  = 1'b1;
            bus.port_req_tag_in = 2'(i);
            bus.port_data_out   = 16'hC000 + 16'(i);
            next_cycle;
        end
        bus.port_valid_out = 1'b0;
        sample;
        expect_eq("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
        expect_eq("bp_hold_data", 32'(bus.rsp_data), 32'hC000);
        expect_eq("bp_hold_ready", 32'(bus.req_ready), 32'd0);
        next_cycle;
        bus.rsp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            sample;
            expect_eq("bp_rsp_valid", 32'(bus.rsp_valid), (j < 4) ? 32'd1 : 32'd0);
            if (j < 4) expect_eq("bp_rsp_data", 32'(bus.rsp_data), 32'(16'hC000 + 16'(j)));
            expect_eq("bp_req_ready", 32'(bus.req_ready), (j >= 1) ? 32'd1 : 32'd0);
            next_cycle;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
